demux_1x8_32_reg: RTL

DEMUX_1X8_32_REG -- requirements
Module: demux_1x8_32_reg

---
 rtl/demux_1x8_32_reg.sv | 116 +++++++++++
 1 files changed

// File: rtl/demux_1x8_32_reg.sv
// demux_1x8_32_reg: 1-to-8 registered demultiplexer, 32-bit data.
//
// Each write stores 'in' into one of eight output registers. The chosen
// output's sticky valid bit is set at the same time.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset     - synchronous, active-high reset; takes priority over we and clr
//   in        - 32-bit write data
//   s         - destination select used in direct mode (0 -> out0 .. 7 -> out7)
//   we        - write strobe, one write per cycle while high
//   auto_inc  - selects ptr instead of s as the destination
//   clr       - clears all valid bits; data registers keep their contents
//   out0..7   - registered destination data
//   valid     - sticky per-destination written flags (bit k belongs to outk)
//   full      - combinational, high exactly when every valid bit is set
//   ptr       - auto-increment destination pointer
//
// Configuration:
//   DEMUX_AUTO_INC_EN - when defined, compiles in the ptr register and the
//   auto_inc behaviour. When undefined, auto_inc is ignored, the destination
//   is always s, and ptr is held at 3'b000.
module demux_1x8_32_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic [2:0]  s,
  input  logic        we,
  input  logic        auto_inc,
  input  logic        clr,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic [31:0] out3,
  output logic [31:0] out4,
  output logic [31:0] out5,
  output logic [31:0] out6,
  output logic [31:0] out7,
  output logic [7:0]  valid,
  output logic        full,
  output logic [2:0]  ptr
);

  logic [31:0] data_q [8];
  logic [31:0] data_d [8];
  logic [7:0]  valid_q, valid_d;
  logic [2:0]  dst;

`ifdef DEMUX_AUTO_INC_EN
  logic [2:0] ptr_q, ptr_d;

  assign dst = auto_inc ? ptr_q : s;
  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (we && auto_inc) begin
      ptr_d = ptr_q + 3'd1;  // 3-bit wrap gives the modulo-8 behaviour
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'b000;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_auto_inc;

  assign unused_auto_inc = auto_inc;
  assign dst             = s;
  assign ptr             = 3'b000;
`endif

  // Everything that depends on s/in is gated by we, so X on those inputs
  // while idle cannot reach the state.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = 8'h00;
    end
    if (we) begin
      data_d[dst]  = in;
      valid_d[dst] = 1'b1;  // on a clr collision only this bit survives
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= 32'h0000_0000;
      end
      valid_q <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
    end
  end

  assign out0  = data_q[0];
  assign out1  = data_q[1];
  assign out2  = data_q[2];
  assign out3  = data_q[3];
  assign out4  = data_q[4];
  assign out5  = data_q[5];
  assign out6  = data_q[6];
  assign out7  = data_q[7];
  assign valid = valid_q;
  assign full  = &valid_q;

endmodule
